// File: rtl/prog_down_counter_pkg.sv
// Shared types and defaults for the programmable down counter.
package prog_down_counter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/prog_down_counter.sv
// Programmable down counter with latch/decrement strobes, one-shot or
// auto-reload operation and a registered terminal-count pulse.
module prog_down_counter
  import prog_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             latch,
  input  logic             dec,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] counter,
  output logic             zero,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] counter_q, counter_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;

    if (latch) begin
      counter_d = in;
      reload_d  = in;
      state_d   = (in != '0) ? COUNT : IDLE;
    end else begin
      case (state_q)
        COUNT: begin
          if (dec) begin
            if (counter_q > ONE) begin
              counter_d = counter_q - ONE;
            end else if (counter_q == ONE) begin
              counter_d = '0;
              tc_d      = 1'b1;
            end else if (auto_reload) begin
              // Zero is held for one dec step before reloading, giving a
              // period of reload value + 1 strobes.
              counter_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end
        end
        IDLE, DONE: begin
          state_d = state_q;
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
        end
      endcase
    end

    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      counter_q <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
    end
  end

  assign counter = counter_q;
  assign zero    = (counter_q == '0);
  assign tc      = tc_q;
  assign busy    = busy_q;

endmodule
